// File: rtl/bsg_link_sched_pkg.sv
// Shared types and helpers for the upstream link scheduler.
package bsg_link_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_MAX_CREDITS = 16;
  localparam int unsigned DEFAULT_TOKEN_WORTH = 8;

  function automatic int unsigned credit_w(input int unsigned max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/bsg_link_rr_arb.sv
// Round-robin picker: first asserted request strictly after ptr_i, wrapping.
module bsg_link_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               v_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      j = (32'(ptr_i) + off) % NUM_REQ;
      if (!v_o && req_i[j]) begin
        v_o        = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bsg_link_upstream_sched.sv
// Credit-gated round-robin scheduler for one upstream link channel.
// Optional BSG_LINK_SCHED_STATS_EN adds sent/stall counters.
module bsg_link_upstream_sched
  import bsg_link_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned MAX_CREDITS = DEFAULT_MAX_CREDITS,
  parameter int unsigned TOKEN_WORTH = DEFAULT_TOKEN_WORTH,
  parameter int unsigned INIT_CYCLES = 4,
  localparam int unsigned CREDIT_W   = credit_w(MAX_CREDITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_v_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     out_v_o,
  output logic [WIDTH-1:0]         out_data_o,
  input  logic                     out_ready_i,
  input  logic                     token_i,
  input  logic                     flush_i,
  output logic                     drained_o,
  output logic [CREDIT_W-1:0]      credit_o,
`ifdef BSG_LINK_SCHED_STATS_EN
  output logic [31:0]              sent_cnt_o,
  output logic [31:0]              stall_cnt_o,
`endif
  output logic                     err_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

  state_e                state_q, state_d;
  logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  out_v_q, out_v_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  err_q, err_d;
  logic                  drained_q, drained_d;
  logic [SUM_W-1:0]      credit_sum;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_v;
  logic                  grant_en;
  logic                  accept;

  bsg_link_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (req_v_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .v_o     (arb_v)
  );

  // A grant needs RUN, a credit, and room in the output register this cycle.
  assign grant_en    = (state_q == ST_RUN) && (credit_q != '0) && (!out_v_q || out_ready_i);
  assign accept      = grant_en && arb_v;
  assign req_ready_o = grant_en ? arb_grant : '0;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    err_d      = err_q;

    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + INIT_W'(1);
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1))
          state_d = flush_i ? ST_DRAIN : ST_RUN;
      end
      ST_RUN:   if (flush_i)  state_d = ST_DRAIN;
      ST_DRAIN: if (!flush_i) state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase

    if (accept) begin
      out_v_d    = 1'b1;
      out_data_d = req_data_i[32'(arb_idx)*WIDTH +: WIDTH];
      rr_ptr_d   = arb_idx;
    end else if (out_v_q && out_ready_i) begin
      out_v_d    = 1'b0;
      out_data_d = '0;
    end

    // Grant and token net out in one update; overflow saturates and latches err.
    credit_sum = SUM_W'(credit_q) - SUM_W'(accept) + (token_i ? SUM_W'(TOKEN_WORTH) : SUM_W'(0));
    credit_d   = credit_sum[CREDIT_W-1:0];
    if (credit_sum > SUM_W'(MAX_CREDITS)) begin
      credit_d = CREDIT_W'(MAX_CREDITS);
      err_d    = 1'b1;
    end

    drained_d = (state_d == ST_DRAIN) && (credit_d == CREDIT_W'(MAX_CREDITS)) && !out_v_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      credit_q   <= CREDIT_W'(MAX_CREDITS);
      err_q      <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      drained_q  <= drained_d;
    end
  end

  assign out_v_o    = out_v_q;
  assign out_data_o = out_data_q;
  assign credit_o   = credit_q;
  assign err_o      = err_q;
  assign drained_o  = drained_q;

`ifdef BSG_LINK_SCHED_STATS_EN
  logic [31:0] sent_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_v_q && out_ready_i)
        sent_cnt_q <= sent_cnt_q + 32'd1;
      if ((state_q == ST_RUN) && (|req_v_i) && (credit_q == '0))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sent_cnt_o  = sent_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_link_upstream_sched.sv
// Randomized bench for bsg_link_upstream_sched against a cycle-level reference model.
module tb_bsg_link_upstream_sched;

  localparam int NR    = 4;
  localparam int W     = 64;
  localparam int MAXC  = 16;
  localparam int TW    = 8;
  localparam int INITC = 4;
  localparam int CW    = $clog2(MAXC + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_v_i;
  logic [NR*W-1:0]   req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic              out_v_o;
  logic [W-1:0]      out_data_o;
  logic              out_ready_i;
  logic              token_i;
  logic              flush_i;
  logic              drained_o;
  logic [CW-1:0]     credit_o;
  logic              err_o;
`ifdef BSG_LINK_SCHED_STATS_EN
  logic [31:0]       sent_cnt_o, stall_cnt_o;
`endif

  always #5 clk = ~clk;

  bsg_link_upstream_sched #(
    .NUM_REQ(NR), .WIDTH(W), .MAX_CREDITS(MAXC), .TOKEN_WORTH(TW), .INIT_CYCLES(INITC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .token_i(token_i), .flush_i(flush_i), .drained_o(drained_o),
    .credit_o(credit_o),
`ifdef BSG_LINK_SCHED_STATS_EN
    .sent_cnt_o(sent_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0=init, 1=run, 2=drain; m_last = last granted requester.
  int          m_mode, m_init_cnt, m_credit, m_last;
  bit          m_err, m_out_v, m_drained;
  logic [63:0] m_out_data;
  logic [63:0] pay [NR];

  task automatic model_reset();
    m_mode = 0; m_init_cnt = 0; m_credit = MAXC; m_last = NR - 1;
    m_err = 0; m_out_v = 0; m_out_data = '0; m_drained = 0;
  endtask

  function automatic int pick(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (m_last + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_regs();
    chk("out_v", 64'(out_v_o), 64'(m_out_v));
    chk("out_data", out_data_o, m_out_data);
    chk("credit", 64'(credit_o), 64'(m_credit));
    chk("err", 64'(err_o), 64'(m_err));
    chk("drained", 64'(drained_o), 64'(m_drained));
  endtask

  // Entered at posedge+1: drive one cycle of inputs, check grant, advance model.
  task automatic cycle(input logic [NR-1:0] v, input bit rdy, input bit tok, input bit fl);
    int g;
    int nc;
    logic [NR-1:0] exp_ready;
    req_v_i = v;
    for (int i = 0; i < NR; i++) begin
      pay[i] = {$urandom, $urandom};
      req_data_i[i*W +: W] = pay[i];
    end
    out_ready_i = rdy; token_i = tok; flush_i = fl;
    #1;
    g = -1;
    if (m_mode == 1 && m_credit != 0 && (!m_out_v || rdy)) g = pick(v);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    @(posedge clk); #1;
    if (g >= 0) begin
      m_out_v = 1; m_out_data = pay[g]; m_last = g;
    end else if (m_out_v && rdy) begin
      m_out_v = 0; m_out_data = '0;
    end
    nc = m_credit - (g >= 0 ? 1 : 0) + (tok ? TW : 0);
    if (nc > MAXC) begin nc = MAXC; m_err = 1; end
    m_credit = nc;
    if (m_mode == 0) begin
      m_init_cnt++;
      if (m_init_cnt == INITC) m_mode = fl ? 2 : 1;
    end else if (m_mode == 1 && fl) m_mode = 2;
    else if (m_mode == 2 && !fl) m_mode = 1;
    m_drained = (m_mode == 2) && (m_credit == MAXC) && !m_out_v;
    check_regs();
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", 64'(req_ready_o), 64'(0));
    chk("rst_out_v", 64'(out_v_o), 64'(0));
    chk("rst_out_data", out_data_o, 64'(0));
    chk("rst_credit", 64'(credit_o), 64'(MAXC));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_drained", 64'(drained_o), 64'(0));
  endtask

  task automatic random_run(input int n);
    bit fl;
    fl = 0;
    for (int i = 0; i < n; i++) begin
      logic [NR-1:0] v;
      if ($urandom_range(39) == 0) fl = ~fl;
      v = ($urandom_range(3) == 0) ? '1 : NR'($urandom);
      cycle(v, $urandom_range(3) != 0, $urandom_range(5) == 0, fl);
    end
  endtask

  initial begin
    rst = 1'b1; req_v_i = '0; req_data_i = '0;
    out_ready_i = 1'b0; token_i = 1'b0; flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;

    // INIT hold-off, then 16 round-robin beats exhaust credits.
    repeat (24) cycle('1, 1, 0, 0);
    chk("credit_exhausted", 64'(credit_o), 64'(0));
    // One token buys exactly 8 more beats.
    cycle('1, 1, 1, 0);
    chk("credit_after_token", 64'(credit_o), 64'(TW));
    repeat (12) cycle('1, 1, 0, 0);
    chk("credit_exhausted2", 64'(credit_o), 64'(0));
    // Overflow: three tokens from zero saturate and set err.
    repeat (3) cycle('0, 1, 1, 0);
    chk("credit_sat", 64'(credit_o), 64'(MAXC));
    chk("err_sticky", 64'(err_o), 64'(1));
    // Backpressure with a beat held.
    cycle('1, 1, 0, 0);
    repeat (3) cycle('1, 0, 0, 0);
    repeat (3) cycle('1, 1, 0, 0);
    // Flush: send down to 8 credits, drain, return a token.
    while (m_credit > TW) cycle('1, 1, 0, 0);
    cycle('0, 1, 0, 1);
    cycle('0, 1, 1, 1);
    cycle('1, 1, 0, 1);
    chk("drained_hi", 64'(drained_o), 64'(1));
    cycle('1, 1, 0, 0);
    chk("drained_lo", 64'(drained_o), 64'(0));
    cycle('1, 1, 0, 0);

    random_run(400);

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    random_run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
